// File: rtl/mips_cache_pkg.sv
// Shared types and width helpers for the direct-mapped MIPS data cache.
// Contents:
//   cache_state_e - controller states (compare / write-back / allocate)
//   clog2_w       - ceiling log2, returns 0 for n <= 1
//   off_w, idx_w, tag_w, blk_w - derived field widths from the cache geometry
package mips_cache_pkg;

  typedef enum logic [1:0] {
    StCompare,
    StWriteback,
    StAllocate
  } cache_state_e;

  function automatic int unsigned clog2_w(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

  function automatic int unsigned off_w(input int unsigned words_per_line);
    return clog2_w(words_per_line);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_lines);
    return clog2_w(num_lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned num_lines,
                                        input int unsigned words_per_line);
    return addr_w - clog2_w(num_lines) - clog2_w(words_per_line);
  endfunction

  function automatic int unsigned blk_w(input int unsigned data_w,
                                        input int unsigned words_per_line);
    return data_w * words_per_line;
  endfunction

endpackage

// File: rtl/mips_cache_array.sv
// Line storage for the direct-mapped cache: valid, dirty, tag and block data per line.
// Ports:
//   clk_i, rst_i          - clock; synchronous active-high reset clears valid/dirty only
//   idx_i                 - line index for both the combinational read and the writes
//   valid_o/dirty_o/tag_o/blk_o - contents of line idx_i (combinational)
//   word_we_i, off_i, word_i    - store one word into the line and mark it dirty
//   fill_we_i, fill_tag_i, fill_blk_i - replace the whole line: valid, clean, new tag
module mips_cache_array #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_LINES      = 8,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned IDX_W          = 3,
  parameter int unsigned TAG_W          = 25,
  parameter int unsigned OFF_SEL_W      = 2,
  parameter int unsigned BLK_W          = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [BLK_W-1:0]     blk_o,
  input  logic                 word_we_i,
  input  logic [OFF_SEL_W-1:0] off_i,
  input  logic [DATA_W-1:0]    word_i,
  input  logic                 fill_we_i,
  input  logic [TAG_W-1:0]     fill_tag_i,
  input  logic [BLK_W-1:0]     fill_blk_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLK_W-1:0]     data_q [NUM_LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign blk_o   = data_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_blk_i;
    end else if (word_we_i) begin
      for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
        if (off_i == OFF_SEL_W'(w)) data_q[idx_i][w*DATA_W +: DATA_W] <= word_i;
      end
    end
  end

endmodule

// File: rtl/mips_dm_cache.sv
// Direct-mapped, write-back, write-allocate data cache between a MIPS core and a block memory.
// Hits are served in the same cycle; a miss stalls the core, writes back a dirty victim and
// then refills the line, after which the held request hits.
// Ports:
//   clk, rst (sync, active high)
//   proc_read/proc_write/proc_addr/proc_wdata - core request (word address)
//   proc_rdata/proc_stall                     - load data and stall back to the core
//   mem_read/mem_write/mem_addr/mem_wdata     - block refill / write-back request
//   mem_rdata/mem_ready                       - refill block and one-cycle completion pulse
module mips_dm_cache
  import mips_cache_pkg::*;
#(
  parameter int unsigned ADDR_W         = 30,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_LINES      = 8,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        proc_read,
  input  logic                                        proc_write,
  input  logic [ADDR_W-1:0]                           proc_addr,
  input  logic [DATA_W-1:0]                           proc_wdata,
  output logic [DATA_W-1:0]                           proc_rdata,
  output logic                                        proc_stall,
  output logic                                        mem_read,
  output logic                                        mem_write,
  output logic [ADDR_W-off_w(WORDS_PER_LINE)-1:0]     mem_addr,
  output logic [blk_w(DATA_W, WORDS_PER_LINE)-1:0]    mem_wdata,
  input  logic [blk_w(DATA_W, WORDS_PER_LINE)-1:0]    mem_rdata,
  input  logic                                        mem_ready
);

  localparam int unsigned OFF_W     = off_w(WORDS_PER_LINE);
  localparam int unsigned IDX_W     = idx_w(NUM_LINES);
  localparam int unsigned TAG_W     = tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);
  localparam int unsigned BLK_W     = blk_w(DATA_W, WORDS_PER_LINE);
  // One-word lines have no offset field; the selector is then a single bit tied to zero.
  localparam int unsigned OFF_SEL_W = (OFF_W > 0) ? OFF_W : 1;

  cache_state_e state_q;
  logic         mem_read_q;
  logic         mem_write_q;

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     idx;
  logic [OFF_SEL_W-1:0] off;

  logic                 line_valid;
  logic                 line_dirty;
  logic [TAG_W-1:0]     line_tag;
  logic [BLK_W-1:0]     line_blk;
  logic [DATA_W-1:0]    hit_word;

  logic hit;
  logic req;
  logic in_compare;
  logic word_we;
  logic fill_we;

  assign req_tag = proc_addr[ADDR_W-1 -: TAG_W];
  assign idx     = proc_addr[OFF_W +: IDX_W];

  if (OFF_W > 0) begin : g_off
    assign off = proc_addr[OFF_SEL_W-1:0];
  end else begin : g_no_off
    assign off = '0;
  end

  mips_cache_array #(
    .DATA_W         (DATA_W),
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W),
    .TAG_W          (TAG_W),
    .OFF_SEL_W      (OFF_SEL_W),
    .BLK_W          (BLK_W)
  ) u_array (
    .clk_i      (clk),
    .rst_i      (rst),
    .idx_i      (idx),
    .valid_o    (line_valid),
    .dirty_o    (line_dirty),
    .tag_o      (line_tag),
    .blk_o      (line_blk),
    .word_we_i  (word_we),
    .off_i      (off),
    .word_i     (proc_wdata),
    .fill_we_i  (fill_we),
    .fill_tag_i (req_tag),
    .fill_blk_i (mem_rdata)
  );

  always_comb begin
    hit_word = '0;
    for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
      if (off == OFF_SEL_W'(w)) hit_word = line_blk[w*DATA_W +: DATA_W];
    end
  end

  assign in_compare = (state_q == StCompare);
  assign hit        = line_valid && (line_tag == req_tag);
  assign req        = proc_read | proc_write;
  assign word_we    = in_compare && hit && proc_write;
  assign fill_we    = (state_q == StAllocate) && mem_ready;

  // Stall is combinational in compare so a miss holds the core in the very cycle it is seen.
  assign proc_stall = !in_compare || (req && !hit);
  assign proc_rdata = (in_compare && hit) ? hit_word : '0;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = (state_q == StWriteback) ? {line_tag, idx} : {req_tag, idx};
  assign mem_wdata  = line_blk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCompare;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      unique case (state_q)
        StCompare: begin
          if (req && !hit) begin
            if (line_valid && line_dirty) begin
              state_q     <= StWriteback;
              mem_write_q <= 1'b1;
            end else begin
              state_q    <= StAllocate;
              mem_read_q <= 1'b1;
            end
          end
        end
        StWriteback: begin
          if (mem_ready) begin
            state_q     <= StAllocate;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
          end
        end
        StAllocate: begin
          if (mem_ready) begin
            state_q    <= StCompare;
            mem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StCompare;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dm_cache.sv
// Directed bench for mips_dm_cache: default geometry plus a 4-line, 1-word-per-line instance.
// Each memory model raises mem_ready three cycles after a request appears; word n holds n*3.
module tb_mips_dm_cache;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- default instance ----------------
  logic         p1_read, p1_write, p1_stall;
  logic [29:0]  p1_addr;
  logic [31:0]  p1_wdata, p1_rdata;
  logic         m1_read, m1_write, m1_ready;
  logic [27:0]  m1_addr;
  logic [127:0] m1_wdata, m1_rdata;

  mips_dm_cache u_dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (p1_read),
    .proc_write (p1_write),
    .proc_addr  (p1_addr),
    .proc_wdata (p1_wdata),
    .proc_rdata (p1_rdata),
    .proc_stall (p1_stall),
    .mem_read   (m1_read),
    .mem_write  (m1_write),
    .mem_addr   (m1_addr),
    .mem_wdata  (m1_wdata),
    .mem_rdata  (m1_rdata),
    .mem_ready  (m1_ready)
  );

  logic [31:0] mem1 [256];
  logic        loaded1 = 1'b0;
  int          cnt1;

  always_comb begin
    for (int i = 0; i < 4; i++) m1_rdata[i*32 +: 32] = mem1[{m1_addr[5:0], 2'(i)}];
  end

  always @(posedge clk) begin
    if (rst) begin
      m1_ready <= 1'b0;
      cnt1     <= 0;
      if (!loaded1) begin
        for (int i = 0; i < 256; i++) mem1[i] <= 32'(i * 3);
        loaded1 <= 1'b1;
      end
    end else if (m1_ready) begin
      m1_ready <= 1'b0;
      cnt1     <= 0;
    end else if (m1_read || m1_write) begin
      if (cnt1 == 2) begin
        m1_ready <= 1'b1;
        cnt1     <= 0;
        if (m1_write) begin
          for (int i = 0; i < 4; i++) mem1[{m1_addr[5:0], 2'(i)}] <= m1_wdata[i*32 +: 32];
        end
      end else begin
        cnt1 <= cnt1 + 1;
      end
    end
  end

  // ---------------- 4-line, 1-word-per-line instance ----------------
  logic        p2_read, p2_write, p2_stall;
  logic [29:0] p2_addr;
  logic [31:0] p2_wdata, p2_rdata;
  logic        m2_read, m2_write, m2_ready;
  logic [29:0] m2_addr;
  logic [31:0] m2_wdata, m2_rdata;

  mips_dm_cache #(
    .NUM_LINES      (4),
    .WORDS_PER_LINE (1)
  ) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (p2_read),
    .proc_write (p2_write),
    .proc_addr  (p2_addr),
    .proc_wdata (p2_wdata),
    .proc_rdata (p2_rdata),
    .proc_stall (p2_stall),
    .mem_read   (m2_read),
    .mem_write  (m2_write),
    .mem_addr   (m2_addr),
    .mem_wdata  (m2_wdata),
    .mem_rdata  (m2_rdata),
    .mem_ready  (m2_ready)
  );

  logic [31:0] mem2 [64];
  logic        loaded2 = 1'b0;
  int          cnt2;

  assign m2_rdata = mem2[m2_addr[5:0]];

  always @(posedge clk) begin
    if (rst) begin
      m2_ready <= 1'b0;
      cnt2     <= 0;
      if (!loaded2) begin
        for (int i = 0; i < 64; i++) mem2[i] <= 32'(i * 3);
        loaded2 <= 1'b1;
      end
    end else if (m2_ready) begin
      m2_ready <= 1'b0;
      cnt2     <= 0;
    end else if (m2_read || m2_write) begin
      if (cnt2 == 2) begin
        m2_ready <= 1'b1;
        cnt2     <= 0;
        if (m2_write) mem2[m2_addr[5:0]] <= m2_wdata;
      end else begin
        cnt2 <= cnt2 + 1;
      end
    end
  end

  // Traffic seen during the last access on the default instance.
  logic         saw_rd, saw_wr, first_wr, both_hi;
  logic [27:0]  rd_addr, wr_addr;
  logic [127:0] wr_blk;

  task automatic access1(input logic rd, input logic wr, input logic [29:0] addr,
                         input logic [31:0] wd, output int stalls, output logic [31:0] rdata);
    @(negedge clk);
    p1_read  = rd;
    p1_write = wr;
    p1_addr  = addr;
    p1_wdata = wd;
    stalls   = 0;
    saw_rd   = 1'b0;
    saw_wr   = 1'b0;
    first_wr = 1'b0;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_blk   = '0;
    #1;
    while (p1_stall && stalls < 50) begin
      if (m1_read && m1_write) both_hi = 1'b1;
      if (m1_write && !saw_wr) begin
        saw_wr   = 1'b1;
        wr_addr  = m1_addr;
        wr_blk   = m1_wdata;
        first_wr = !saw_rd;
      end
      if (m1_read && !saw_rd) begin
        saw_rd  = 1'b1;
        rd_addr = m1_addr;
      end
      stalls++;
      @(negedge clk);
      #1;
    end
    rdata = p1_rdata;
    @(negedge clk);
    p1_read  = 1'b0;
    p1_write = 1'b0;
  endtask

  task automatic access2(input logic [29:0] addr, output int stalls, output logic [31:0] rdata);
    @(negedge clk);
    p2_read = 1'b1;
    p2_addr = addr;
    stalls  = 0;
    #1;
    while (p2_stall && stalls < 50) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rdata = p2_rdata;
    @(negedge clk);
    p2_read = 1'b0;
  endtask

  int          st;
  logic [31:0] rd;

  initial begin
    rst      = 1'b1;
    both_hi  = 1'b0;
    p1_read  = 1'b0;
    p1_write = 1'b0;
    p1_addr  = '0;
    p1_wdata = '0;
    p2_read  = 1'b0;
    p2_write = 1'b0;
    p2_addr  = '0;
    p2_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_stall", 32'(p1_stall), 32'd0);
    check("reset_mem_read", 32'(m1_read), 32'd0);
    check("reset_mem_write", 32'(m1_write), 32'd0);
    check("reset_rdata", p1_rdata, 32'd0);

    // Cold read fills line 0.
    access1(1'b1, 1'b0, 30'h00, 32'h0, st, rd);
    check("cold_stalls", 32'(st), 32'd5);
    check("cold_mem_read", 32'(saw_rd), 32'd1);
    check("cold_mem_addr", 32'(rd_addr), 32'h0);
    check("cold_no_wb", 32'(saw_wr), 32'd0);
    check("cold_rdata", rd, 32'd0);
    access1(1'b1, 1'b0, 30'h02, 32'h0, st, rd);
    check("hit02_stalls", 32'(st), 32'd0);
    check("hit02_rdata", rd, 32'd6);

    // Write hit, then read it back with no memory traffic.
    access1(1'b0, 1'b1, 30'h01, 32'hDEAD, st, rd);
    check("whit_stalls", 32'(st), 32'd0);
    check("whit_traffic", 32'(saw_rd | saw_wr), 32'd0);
    access1(1'b1, 1'b0, 30'h01, 32'h0, st, rd);
    check("rd01_stalls", 32'(st), 32'd0);
    check("rd01_rdata", rd, 32'hDEAD);
    check("rd01_traffic", 32'(saw_rd | saw_wr), 32'd0);

    // Conflict on index 0 with a dirty victim.
    access1(1'b1, 1'b0, 30'h20, 32'h0, st, rd);
    check("conf_wb_first", 32'(first_wr), 32'd1);
    check("conf_wb_addr", 32'(wr_addr), 32'h0);
    check("conf_wb_word1", wr_blk[63:32], 32'hDEAD);
    check("conf_wb_word2", wr_blk[95:64], 32'd6);
    check("conf_rd_addr", 32'(rd_addr), 32'h8);
    check("conf_rdata", rd, 32'h60);
    check("conf_stalls", 32'(st), 32'd9);

    // Write miss into clean, invalid line 1.
    access1(1'b0, 1'b1, 30'h45, 32'h1234, st, rd);
    check("wmiss_no_wb", 32'(saw_wr), 32'd0);
    check("wmiss_rd_addr", 32'(rd_addr), 32'h11);
    check("wmiss_stalls", 32'(st), 32'd5);
    access1(1'b1, 1'b0, 30'h45, 32'h0, st, rd);
    check("rd45_rdata", rd, 32'h1234);
    check("rd45_stalls", 32'(st), 32'd0);
    // Evicting line 1 must write back the merged word, proving it went dirty.
    access1(1'b1, 1'b0, 30'h65, 32'h0, st, rd);
    check("ev65_wb", 32'(saw_wr), 32'd1);
    check("ev65_wb_addr", 32'(wr_addr), 32'h11);
    check("ev65_wb_word1", wr_blk[63:32], 32'h1234);
    check("ev65_rd_addr", 32'(rd_addr), 32'h19);
    check("ev65_rdata", rd, 32'h12F);
    check("ev65_stalls", 32'(st), 32'd9);

    // Reset in the second stall cycle of a clean miss.
    @(negedge clk);
    p1_read = 1'b1;
    p1_addr = 30'h00;
    #1;
    check("rmid_miss_stall", 32'(p1_stall), 32'd1);
    @(negedge clk);
    #1;
    check("rmid_alloc_read", 32'(m1_read), 32'd1);
    rst     = 1'b1;
    p1_read = 1'b0;
    @(negedge clk);
    #1;
    check("rmid_mem_read", 32'(m1_read), 32'd0);
    check("rmid_stall", 32'(p1_stall), 32'd0);
    rst = 1'b0;
    access1(1'b1, 1'b0, 30'h02, 32'h0, st, rd);
    check("rmid_reread_stalls", 32'(st), 32'd5);
    check("rmid_reread_rdata", rd, 32'd6);
    check("rmid_reread_addr", 32'(rd_addr), 32'h0);

    // Small geometry: every first access misses; descending re-reads hit only 15..12.
    for (int a = 0; a < 16; a++) begin
      access2(30'(a), st, rd);
      check("sweep_first_stalls", 32'(st), 32'd5);
      check("sweep_first_data", rd, 32'(a * 3));
    end
    for (int a = 15; a >= 0; a--) begin
      access2(30'(a), st, rd);
      check("sweep_reread_stalls", 32'(st), (a >= 12) ? 32'd0 : 32'd5);
      check("sweep_reread_data", rd, 32'(a * 3));
    end

    check("rd_wr_never_both", 32'(both_hi), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_dm_cache.md
Name: mips_dm_cache

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache.
- Sits between the single-cycle/pipelined MIPS core's data port and a slow, block-wide data memory.
- Serves hits in the same cycle with no stall.
- On a miss it stalls the core, writes back a dirty victim if needed, then refills the line.

Parameters:
- ADDR_W, 30, word-address width from the core (byte address [31:2]).
- DATA_W, 32, data word width.
- NUM_LINES, 8, number of cache lines; power of two, >=2.
- WORDS_PER_LINE, 4, words per block; power of two, >=1.
- Derived, not overridable:
  - OFF_W = log2(WORDS_PER_LINE)
  - IDX_W = log2(NUM_LINES)
  - TAG_W = ADDR_W-IDX_W-OFF_W
  - BLK_W = DATA_W*WORDS_PER_LINE

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- proc_read  in  1  core load request.
- proc_write  in  1  core store request.
- proc_addr  in  ADDR_W  word address.
- proc_wdata  in  DATA_W  store data.
- proc_rdata  out  DATA_W  load data; valid when proc_read=1 and proc_stall=0.
- proc_stall  out  1  core must hold its request and PC while high.
- mem_read  out  1  block refill request.
- mem_write  out  1  block write-back request.
- mem_addr  out  ADDR_W-OFF_W  block address.
- mem_wdata  out  BLK_W  victim block; word 0 in the LSBs.
- mem_rdata  in  BLK_W  refill block; word 0 in the LSBs.
- mem_ready  in  1  one-cycle pulse: memory has completed the current read or write.

Behaviour:
- Address split: tag = addr[ADDR_W-1 -: TAG_W], index = next IDX_W bits, offset = low OFF_W bits.
- Storage per line: valid, dirty, tag, BLK_W data.
- States: COMPARE, WRITEBACK, ALLOCATE.
- Reset (sync):
  - All valid and dirty bits clear; state=COMPARE.
  - mem_read=0, mem_write=0, proc_stall=0, proc_rdata=0.
  - Data/tag contents unspecified.
- COMPARE:
  - hit = valid[idx] && tag match.
  - req = proc_read|proc_write.
  - No req: stall=0, no state change.
  - Read hit: proc_rdata = addressed word, combinational, same cycle; stall=0.
  - Write hit: addressed word <= proc_wdata and dirty <= 1 at the edge; stall=0.
  - Miss: stall=1 combinationally in the same cycle. Next state is WRITEBACK if valid&&dirty, else ALLOCATE.
- WRITEBACK:
  - stall=1, mem_write=1.
  - mem_addr = {stored tag, idx}; mem_wdata = stored block.
  - Hold all outputs until mem_ready, then go to ALLOCATE.
- ALLOCATE:
  - stall=1, mem_read=1, mem_addr = {req tag, idx}.
  - On mem_ready: line <= mem_rdata, tag <= req tag, valid <= 1, dirty <= 0, go to COMPARE.
  - The retried access hits in the next cycle; a write is merged then and sets dirty.
- mem_read and mem_write are never high together. Both are low in COMPARE.
- mem_ready arriving in COMPARE is ignored.
- Timing:
  - Clean miss costs 2 + L stall cycles, where L = cycles from request to mem_ready.
  - Dirty miss costs 3 + Lw + Lr stall cycles.
- proc_read and proc_write both high: treated as a write; proc_rdata still reflects the hit word.
- The core holds proc_* stable while stalled. The cache latches nothing from proc_*, so changed inputs mid-stall are illegal.
- Reset mid-miss: the FSM returns to COMPARE and mem_* go low after the edge. Any in-flight memory transaction is abandoned; the memory model must also reset.
- Index wrap: addresses differing only in tag map to the same line and evict each other. No associativity.

Decomposition:
- Package mips_cache_pkg holds:
  - state enum {COMPARE, WRITEBACK, ALLOCATE}
  - clog2-style width helper
  - derived-width localparam formulas
- One sub-module, mips_cache_array: valid/dirty/tag/data arrays with a synchronous-reset valid/dirty clear.
  - Combinational read.
  - Write ports: word write (hit) and block write (refill).
- The FSM and hit logic stay in mips_dm_cache.

Test Plan (defaults; memory model with mem_ready 3 cycles after request, preloaded mem word n = n*3):
- Cold read addr 0x00 -> stall for 5 cycles, mem_read with mem_addr=0x0, then proc_rdata=0 with no stall. Read 0x02 next -> immediate 6, no stall.
- Write hit 0x01 with 0xDEAD after the line is filled -> stall stays 0; read 0x01 -> 0xDEAD; no mem traffic.
- Conflict: read 0x20, which has the same index 0 as line 0x00 (dirty) -> mem_write first with mem_addr=0x0 and word1=0xDEAD in mem_wdata. Then mem_read with mem_addr=0x8. proc_rdata=0x60, total stall 9 cycles.
- Write miss 0x45 data 0x1234 into clean invalid line 1 -> ALLOCATE only, mem_addr=0x11. Then the word is written, dirty=1, and read 0x45 returns 0x1234.
- Assert rst during ALLOCATE (2nd stall cycle) -> next cycle mem_read=0, stall=0 with no request. A re-read of 0x00 misses again (valid cleared).
- Parameter sweep NUM_LINES=4, WORDS_PER_LINE=1: sequential reads 0..15 then re-reads -> every first access misses once, re-read hits for the last 4 only; data matches n*3.
